// File: rtl/uart_rx_byte.sv
// UART receiver: 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB first, into a valid/ready holding register.
// Framing, parity and overrun errors are reported as single-cycle pulses.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 43
) (
  input  logic       user_clock,
  input  logic       rst,
  input  logic       usb_rs232_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic [1:0]       rxd_sync_q, rxd_sync_d;
  logic             rxd_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_err_q, overrun_err_d;
  logic             busy_q, busy_d;
  logic             deliver;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  assign rxd_sync_d = {rxd_sync_q[0], usb_rs232_rxd};
  assign rxd_s      = rxd_sync_q[1];

  // Next-state, datapath and delivery logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    bit_d         = bit_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    deliver       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d         = par_q;
    parity_err_d  = 1'b0;
`endif

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rxd_s;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // A same-cycle handshake frees the slot for the new byte
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      parity_err_d = (^shift_q) != par_q;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge user_clock or negedge rst) begin
    if (!rst) begin
      rxd_sync_q    <= 2'b11;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      rxd_sync_q    <= rxd_sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q         <= par_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: directed frames push expected events, a monitor pops and compares.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_byte;

  localparam int unsigned CPB = 43;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  // Pin drive to visible output: 2 sync cycles + 1 into START + half bit + data/parity/stop bits
  localparam int unsigned LAT   = 3 + CPB / 2 + (9 + P) * CPB;
  localparam int unsigned FRAME = (10 + P) * CPB;

  localparam int K_BYTE  = 0;
  localparam int K_FRAME = 1;
  localparam int K_PAR   = 2;
  localparam int K_OVR   = 3;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned at;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;
  logic       busy;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  ev_t         exp_q[$];
  logic        prev_valid = 1'b0;
  logic        prev_hs    = 1'b0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .user_clock    (clk),
    .rst           (rst),
    .usb_rs232_rxd (rxd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_err     (frame_err),
    .parity_err    (parity_err),
    .overrun_err   (overrun_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data, input int unsigned at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [7:0] data);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h at cycle %0d, expected none", kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_BYTE && e.data !== data) || (e.at != 0 && e.at != cyc)) begin
        fails++;
        $display("FAIL event: got kind %0d data 0x%0h cycle %0d, expected kind %0d data 0x%0h cycle %0d",
                 kind, data, cyc, e.kind, e.data, e.at);
      end
    end
  endtask

  // Monitor: a byte is newly presented when valid rises or follows a handshake
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (rx_valid && (!prev_valid || prev_hs)) observe(K_BYTE, rx_data);
      if (frame_err)   observe(K_FRAME, 8'h00);
      if (parity_err)  observe(K_PAR, 8'h00);
      if (overrun_err) observe(K_OVR, 8'h00);
      prev_valid = rx_valid;
      prev_hs    = rx_valid && rx_ready;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ bad_par);
`else
    if (bad_par) $display("note: parity bit not sent in 8N1 build");
`endif
    send_bit(stop);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    int unsigned c0;
    rst      = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    tick(5);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_errs", {frame_err, parity_err, overrun_err}, 3'b000);
    rst = 1'b1;
    tick(5);

    // Nominal byte with exact output latency
    c0 = cyc;
    push(K_BYTE, 8'hA5, c0 + LAT);
    send_frame(8'hA5, 1'b1, 1'b0);
    check("nominal_data", rx_data, 8'hA5);
    check("nominal_valid", rx_valid, 1'b1);
    check("nominal_busy_idle", busy, 1'b0);
    consume();
    check("nominal_consumed", rx_valid, 1'b0);

    // Back-to-back frames with the consumer always ready
    rx_ready = 1'b1;
    c0 = cyc;
    push(K_BYTE, 8'h00, c0 + LAT);
    push(K_BYTE, 8'hFF, c0 + LAT + FRAME);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    tick(5);
    rx_ready = 1'b0;
    check("b2b_valid_cleared", rx_valid, 1'b0);

    // False start: 10 low cycles, busy must rise at T0+1 and fall again
    rxd = 1'b0;
    tick(2);
    check("false_start_busy_t0", busy, 1'b0);
    tick(1);
    check("false_start_busy_t0p1", busy, 1'b1);
    tick(7);
    rxd = 1'b1;
    tick(40);
    check("false_start_idle", busy, 1'b0);
    c0 = cyc;
    push(K_BYTE, 8'h3C, c0 + LAT);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("after_false_start_data", rx_data, 8'h3C);
    consume();

    // Framing error followed by a held-low break
    c0 = cyc;
    push(K_FRAME, 8'h00, c0 + LAT);
    send_frame(8'h55, 1'b0, 1'b0);
    rxd = 1'b0;
    tick(1000);
    check("break_busy", busy, 1'b1);
    check("break_no_valid", rx_valid, 1'b0);
    rxd = 1'b1;
    tick(5);
    check("break_released", busy, 1'b0);
    c0 = cyc;
    push(K_BYTE, 8'h81, c0 + LAT);
    send_frame(8'h81, 1'b1, 1'b0);
    check("after_break_data", rx_data, 8'h81);
    consume();

    // Overrun: second byte dropped while the first is still held
    c0 = cyc;
    push(K_BYTE, 8'h11, c0 + LAT);
    send_frame(8'h11, 1'b1, 1'b0);
    c0 = cyc;
    push(K_OVR, 8'h00, c0 + LAT);
    send_frame(8'h22, 1'b1, 1'b0);
    check("overrun_data_kept", rx_data, 8'h11);
    check("overrun_valid_kept", rx_valid, 1'b1);
    consume();

    // Handshake in the exact delivery cycle frees the slot
    c0 = cyc;
    push(K_BYTE, 8'h11, c0 + LAT);
    send_frame(8'h11, 1'b1, 1'b0);
    c0 = cyc;
    push(K_BYTE, 8'h22, c0 + LAT);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        tick(LAT - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    check("same_cycle_hs_data", rx_data, 8'h22);
    check("same_cycle_hs_valid", rx_valid, 1'b1);
    consume();

    // Reset during bit 4 of 0xF0 while a byte is held
    c0 = cyc;
    push(K_BYTE, 8'h96, c0 + LAT);
    send_frame(8'h96, 1'b1, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rxd = 1'b1;
    tick(CPB / 2);
    check("pre_reset_busy", busy, 1'b1);
    rst = 1'b0;
    tick(2);
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_rx_valid", rx_valid, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_errs", {frame_err, parity_err, overrun_err}, 3'b000);
    rst = 1'b1;
    tick(5 * CPB);
    c0 = cyc;
    push(K_BYTE, 8'h5A, c0 + LAT);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("after_reset_data", rx_data, 8'h5A);
    consume();

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so a parity bit of 0 is a mismatch; byte still delivered
    c0 = cyc;
    push(K_BYTE, 8'h07, c0 + LAT);
    push(K_PAR, 8'h00, c0 + LAT);
    send_frame(8'h07, 1'b1, 1'b1);
    check("parity_err_data", rx_data, 8'h07);
    consume();
`endif

    tick(50);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Receive half of the board's USB-RS232 link. It samples `usb_rs232_rxd` in the `user_clock` domain and frames 8N1 characters (8E1 with parity enabled), LSB first. Each received byte is presented on a valid/ready holding register for the command logic. Framing, parity and overrun errors are flagged with single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 43: `user_clock` cycles per bit (43 at 40 MHz ≈ 930 kbaud); legal range 8..1023.
- `user_clock`  input  1  system clock (40 MHz).
- `rst`  input  1  reset, asynchronous and active-low.
- `usb_rs232_rxd`  input  1  serial line, asynchronous to `user_clock`, idles high.
- `rx_data`  output  8  last accepted byte.
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  input  1  consumer accepts the byte; a transfer occurs when `rx_valid` && `rx_ready` at a clock edge.
- `frame_err`  output  1  1-cycle pulse: stop bit sampled low.
- `parity_err`  output  1  1-cycle pulse: parity mismatch (constant 0 without the macro).
- `overrun_err`  output  1  1-cycle pulse: byte completed while `rx_valid` was high.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- Input synchronizer: two flops, both reset to 1. All logic uses the second flop output `rxd_s`.
- Bit counter `cnt`: counts 0..CLKS_PER_BIT-1. Width is clog2(CLKS_PER_BIT). Cleared on every state entry.
- Bit index: 3 bits, counts 0..7.
- State machine:
  - IDLE: on `rxd_s`==0 go to START, cnt=0.
  - START: when cnt==H-1, where H = CLKS_PER_BIT/2 (floor), sample. If `rxd_s`==1 (false start), return to IDLE with no flag. Otherwise go to DATA.
  - DATA: sample on cnt==CLKS_PER_BIT-1 and shift in from the MSB side (LSB arrives first). After bit 7, go to PARITY if enabled, else STOP.
  - PARITY: sample on cnt==CLKS_PER_BIT-1, then go to STOP.
  - STOP: sample on cnt==CLKS_PER_BIT-1.
    - Sample 1: deliver the byte, then IDLE.
    - Sample 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxd_s`==1, then IDLE. This covers a line held low.
- Delivery:
  - If `rx_valid`==0: load `rx_data` and set `rx_valid`.
  - If `rx_valid`==1: the new byte is dropped, `rx_data` is unchanged, and `overrun_err` pulses.
  - Delivery and a consumer handshake in the same cycle count as the slot being free: load the new byte, keep `rx_valid`=1, no overrun.
- `rx_valid` clears on a handshake with no simultaneous delivery.
- A byte with a parity error is still delivered, with the `parity_err` pulse in the same cycle as the load. A framing error takes precedence: no delivery and no `parity_err`.
- Reset values: `rx_data`=0x00, `rx_valid`=0, all error pulses 0, `busy`=0, state IDLE, counters 0.
- Reset asserted mid-frame aborts immediately. After release, the receiver hunts for a fresh falling edge; a partial frame in progress may be misframed and must be tolerated.

## Timing
- Let T0 be the first cycle with `rxd_s`==0 in IDLE. The pin-to-`rxd_s` latency is 2 cycles.
- Start sample at T0+H. Data bit i sampled at T0+H+(i+1)·CLKS_PER_BIT.
- Parity sample (if enabled) at T0+H+9·CLKS_PER_BIT.
- Stop sample at T0+H+(9+P)·CLKS_PER_BIT, where P=1 with parity, else 0.
- `rx_valid`, `rx_data` and all error pulses are registered and become visible in the cycle after the stop sample.
- IDLE is entered in that same cycle, so a start bit that immediately follows is not missed. Back-to-back frames are supported.
- `busy` rises at T0+1 and falls with the IDLE transition.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present; the frame is 8E1.
  - Expected parity bit = XOR of the 8 data bits, so the total count of ones is even.
  - `parity_err` pulses on mismatch.
- Not defined:
  - PARITY state and its logic are removed; the frame is 8N1.
  - `parity_err` is tied to 0.

## Test plan
- **Nominal byte** (CLKS_PER_BIT=43): send 0xA5 at 43 cycles/bit, `rx_ready`=0. Expect `rx_data`=0xA5 and `rx_valid`=1 on the cycle after T0+21+9·43; no error pulses.
- **Back-to-back with handshake**: send 0x00 then 0xFF with no idle gap, `rx_ready`=1. Expect two 1-cycle `rx_valid` pulses carrying 0x00 then 0xFF, 430 cycles apart.
- **False start**: drive the line low for 10 cycles, then high. Expect the state to return to IDLE with no `rx_valid` and no flags; a following 0x3C is received correctly.
- **Framing error / break**: send 0x55 with the stop bit low, then hold the line low for 1000 cycles. Expect one `frame_err` pulse, no `rx_valid`, and `busy` high until the line returns high; the next 0x81 is received.
- **Overrun**: send 0x11 then 0x22 with `rx_ready`=0. Expect `rx_data`=0x11 retained and one `overrun_err` pulse at the end of 0x22. Repeat with `rx_ready` pulsed in the exact delivery cycle: expect 0x22 loaded and no overrun.
- **Reset mid-frame and parity**: assert `rst` low during bit 4 of 0xF0. Expect all outputs at their reset values and the next frame received. With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0: expect `rx_data`=0x07 and a `parity_err` pulse in the same cycle.
